// File: rtl/dcpu_mem_bridge_pkg.sv
// Shared definitions for the dcpu memory bridge: FSM state encoding and default geometry.
package dcpu_mem_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PWAIT = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   localparam int DEF_W          = 16;
   localparam int DEF_RAM_AW     = 12;
   localparam int DEF_TMO_CYCLES = 255;

   // RAM occupies [0, 2**RAM_AW); everything above goes to the peripheral port.
   localparam int RAM_BASE = 0;

endpackage

// File: rtl/dcpu_mem_bridge_ram.sv
// Single-port synchronous RAM, 2**AW x W, registered read, write-first.
module dcpu_mem_bridge_ram #(
   parameter int W  = 16,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdat,
   output logic [W-1:0]  q
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdat;
            q         <= wdat;
         end else begin
            q <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dcpu_mem_bridge.sv
// dcpu bus endpoint: decodes each access to on-chip RAM or the peripheral req/ack port, one ack per access.
// Optional peripheral timeout with sticky o_bus_err is enabled by defining DCPU_BRIDGE_TIMEOUT_EN.
module dcpu_mem_bridge
   import dcpu_mem_bridge_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int RAM_AW     = DEF_RAM_AW,
   parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [W-1:0] i_addr,
   input  logic [W-1:0] i_dat,
   input  logic         i_we,
   input  logic         i_cs,
   output logic [W-1:0] o_dat,
   output logic         o_ack,
   output logic [W-1:0] o_p_addr,
   output logic [W-1:0] o_p_dat,
   output logic         o_p_we,
   output logic         o_p_stb,
   input  logic [W-1:0] i_p_dat,
   input  logic         i_p_ack,
   output logic         o_bus_err,
   output logic [1:0]   o_dbg_state
);

   state_t       state, state_nxt;
   logic         ram_hit, take, ram_en, ram_we, tmo_hit;
   logic [W-1:0] ram_q, p_rdat;
   logic         acc_we, acc_ram;

   assign ram_hit = (i_addr >> RAM_AW) == '0;
   assign take    = (state == ST_IDLE) && i_cs;
   // Reset wins over a request arriving in the same cycle, so nothing is committed.
   assign ram_en  = take && ram_hit && !i_reset;
   assign ram_we  = ram_en && i_we;

   dcpu_mem_bridge_ram #(.W(W), .AW(RAM_AW)) u_ram (
      .clk  (i_clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (i_addr[RAM_AW-1:0]),
      .wdat (i_dat),
      .q    (ram_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (i_cs) state_nxt = ram_hit ? ST_ACK : ST_PWAIT;
         ST_PWAIT: if (i_p_ack || tmo_hit) state_nxt = ST_ACK;
         ST_ACK:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ack = 1'b0;
      o_dat = '0;
      if (state == ST_ACK) begin
         o_ack = 1'b1;
         if (!acc_we) o_dat = acc_ram ? ram_q : p_rdat;
      end
   end

   assign o_dbg_state = state;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_p_addr <= '0;
         o_p_dat  <= '0;
         o_p_we   <= 1'b0;
         o_p_stb  <= 1'b0;
         p_rdat   <= '0;
         acc_we   <= 1'b0;
         acc_ram  <= 1'b0;
      end else begin
         if (take) begin
            acc_we  <= i_we;
            acc_ram <= ram_hit;
         end
         if (take && !ram_hit) begin
            o_p_addr <= i_addr;
            o_p_dat  <= i_dat;
            o_p_we   <= i_we;
            o_p_stb  <= 1'b1;
         end
         // A peripheral ack on the expiry cycle takes priority over the timeout.
         if (state == ST_PWAIT) begin
            if (i_p_ack) begin
               p_rdat  <= i_p_dat;
               o_p_stb <= 1'b0;
            end else if (tmo_hit) begin
               p_rdat  <= '0;
               o_p_stb <= 1'b0;
            end
         end
      end
   end

`ifdef DCPU_BRIDGE_TIMEOUT_EN
   localparam int CW = ($clog2(TMO_CYCLES + 1) < 8) ? 8 : $clog2(TMO_CYCLES + 1);

   logic [CW-1:0] tmo_cnt;
   logic          bus_err;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tmo_cnt <= '0;
         bus_err <= 1'b0;
      end else begin
         if (state == ST_PWAIT) tmo_cnt <= tmo_cnt + CW'(1);
         else                   tmo_cnt <= '0;
         if (tmo_hit && !i_p_ack) bus_err <= 1'b1;
      end
   end

   // Counter holds the number of PWAIT cycles already spent; the last allowed one expires.
   assign tmo_hit   = (state == ST_PWAIT) && (tmo_cnt == CW'(TMO_CYCLES - 1));
   assign o_bus_err = bus_err;
`else
   logic unused_tmo;
   assign unused_tmo = (TMO_CYCLES != 0);
   assign tmo_hit    = 1'b0;
   assign o_bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dcpu_mem_bridge.sv
// Self-checking bench for dcpu_mem_bridge: directed cases plus a randomized mix against a memory/latency model.
module tb_dcpu_mem_bridge;

   localparam int W      = 16;
   localparam int RAM_AW = 12;
   localparam int TMO    = 255;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] addr, wdat, o_dat, p_addr, p_wdat, p_dat;
   logic         we, cs, o_ack, p_we, p_stb, p_ack, bus_err;
   logic [1:0]   dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_ack_cyc;
   logic last_ack_err;

   logic [W-1:0] model_mem [int];
   logic [W-1:0] pool [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dcpu_mem_bridge #(.W(W), .RAM_AW(RAM_AW), .TMO_CYCLES(TMO)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_addr      (addr),
      .i_dat       (wdat),
      .i_we        (we),
      .i_cs        (cs),
      .o_dat       (o_dat),
      .o_ack       (o_ack),
      .o_p_addr    (p_addr),
      .o_p_dat     (p_wdat),
      .o_p_we      (p_we),
      .o_p_stb     (p_stb),
      .i_p_dat     (p_dat),
      .i_p_ack     (p_ack),
      .o_bus_err   (bus_err),
      .o_dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One core access; p_lat=0 means the peripheral never answers.
   task automatic access(input string tag, input logic [W-1:0] a, input logic we_i,
                         input logic [W-1:0] d, input int p_lat, input logic [W-1:0] pd,
                         output logic [W-1:0] rd, output int lat, output int stb_n);
      int  c;
      bit  done;
      cs = 1'b1; addr = a; we = we_i; wdat = d;
      c = 0; done = 0; stb_n = 0; rd = '0; lat = -1;
      while (!done && c <= 600) begin
         @(negedge clk);
         if (c == 0) check({tag, " early_ack"}, 32'(o_ack), 32'd0);
         if (p_stb) begin
            stb_n++;
            if (stb_n == 1) begin
               check({tag, " p_addr"}, 32'(p_addr), 32'(a));
               check({tag, " p_we"}, 32'(p_we), 32'(we_i));
               if (we_i) check({tag, " p_dat"}, 32'(p_wdat), 32'(d));
            end
         end
         if (o_ack) begin
            done = 1; lat = c; rd = o_dat;
            last_ack_cyc = cyc; last_ack_err = bus_err;
         end
         p_ack = (p_lat > 0) && p_stb && (stb_n == p_lat);
         p_dat = p_ack ? pd : W'($urandom);
         c++;
      end
      if (!done) check({tag, " ack_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      p_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      cs = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("idle_ack", 32'(o_ack), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic ram_op(input string tag, input logic [W-1:0] a, input logic we_i, input logic [W-1:0] d);
      logic [W-1:0] rd, exp;
      int lat, sn;
      exp = we_i ? '0 : (model_mem.exists(int'(a)) ? model_mem[int'(a)] : 'x);
      access(tag, a, we_i, d, 0, '0, rd, lat, sn);
      check({tag, " lat"}, 32'(lat), 32'd1);
      check({tag, " stb"}, 32'(sn), 32'd0);
      if (!$isunknown(exp)) check({tag, " dat"}, 32'(rd), 32'(exp));
      if (we_i) model_mem[int'(a)] = d;
   endtask

   task automatic per_op(input string tag, input logic [W-1:0] a, input logic we_i, input logic [W-1:0] d,
                         input int p_lat, input logic [W-1:0] pd);
      logic [W-1:0] rd;
      int lat, sn;
      access(tag, a, we_i, d, p_lat, pd, rd, lat, sn);
      check({tag, " lat"}, 32'(lat), 32'(p_lat + 1));
      check({tag, " stb"}, 32'(sn), 32'(p_lat));
      check({tag, " dat"}, 32'(rd), we_i ? 32'd0 : 32'(pd));
   endtask

   initial begin
      logic [W-1:0] rd;
      int lat, sn, w_ack;
      reset = 1'b1; cs = 1'b0; addr = '0; wdat = '0; we = 1'b0; p_ack = 1'b0; p_dat = '0;

      // Reset hold
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_ack", 32'(o_ack), 32'd0);
         check("rst_stb", 32'(p_stb), 32'd0);
         check("rst_err", 32'(bus_err), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      idle(3);

      // RAM write then read, back to back
      ram_op("wr10", 16'h0010, 1'b1, 16'hBEEF);
      w_ack = last_ack_cyc;
      ram_op("rd10", 16'h0010, 1'b0, '0);
      check("ack_gap", 32'(last_ack_cyc - w_ack), 32'd2);
      idle(1);

      // Held-cs stream of RAM writes then 4 reads
      for (int i = 0; i < 4; i++) ram_op("swr", 16'(16'h0100 + i), 1'b1, W'($urandom));
      for (int i = 0; i < 4; i++) ram_op("srd", 16'(16'h0100 + i), 1'b0, '0);
      idle(2);

      // Peripheral read and address-map boundary
      per_op("p8000", 16'h8000, 1'b0, '0, 5, 16'h1234);
      ram_op("b0fff_w", 16'h0FFF, 1'b1, 16'h5A5A);
      ram_op("b0fff_r", 16'h0FFF, 1'b0, '0);
      per_op("b1000", 16'h1000, 1'b0, '0, 1, 16'hC3C3);
      idle(1);

      // Randomized mix
      for (int i = 0; i < 16; i++) begin
         pool[i] = W'($urandom_range(0, 2**RAM_AW - 1));
         ram_op("pre", pool[i], 1'b1, W'($urandom));
      end
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0)
            ram_op("rnd_ram", pool[$urandom_range(0, 15)], 1'($urandom), W'($urandom));
         else
            per_op("rnd_per", W'($urandom_range(2**RAM_AW, 16'hFFFF)), 1'($urandom), W'($urandom),
                   $urandom_range(1, 6), W'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(1);

`ifdef DCPU_BRIDGE_TIMEOUT_EN
      // Timeout: peripheral never answers
      access("tmo", 16'hA000, 1'b0, '0, 0, '0, rd, lat, sn);
      check("tmo lat", 32'(lat), 32'(TMO + 1));
      check("tmo stb", 32'(sn), 32'(TMO));
      check("tmo dat", 32'(rd), 32'd0);
      check("tmo err_at_ack", 32'(last_ack_err), 32'd1);
      idle(3);
      check("tmo err_held", 32'(bus_err), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("tmo err_clr", 32'(bus_err), 32'd0);
      // Peripheral ack on the expiry cycle wins
      per_op("tmo_edge", 16'hA002, 1'b0, '0, TMO, 16'h7E57);
      check("tmo_edge err_at_ack", 32'(last_ack_err), 32'd0);
      idle(1);
      check("tmo_edge err", 32'(bus_err), 32'd0);
`endif

      // Reset during PWAIT aborts without an ack
      cs = 1'b1; addr = 16'h9000; we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort stb_before", 32'(p_stb), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort stb", 32'(p_stb), 32'd0);
      check("abort ack", 32'(o_ack), 32'd0);
      cs = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      idle(3);
      ram_op("post_abort", 16'h0010, 1'b0, '0);
      idle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
